// File: rtl/ntt_reorder_buf.sv
// Ping-pong block buffer for the NTT datapath. One bank fills with a block of
// N = 2**LOGN coefficients in natural order while the other bank drains in
// bit-reversed index order, sustaining one coefficient per cycle.
// Optional feature macro: REORDER_MODE_EN adds a 'mode' input that selects,
// per block, natural-order (mode=1) instead of bit-reversed (mode=0) readout.
module ntt_reorder_buf #(
  parameter int LOGQ = 32,
  parameter int LOGN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] out_data,
  output logic            out_last
`ifdef REORDER_MODE_EN
  ,
  input  logic            mode
`endif
);

  localparam int N = 1 << LOGN;
  localparam logic [LOGN-1:0] LAST = '1;

  // Bank storage; contents are deliberately left uncleared on reset, the
  // full flags alone decide what is visible.
  logic [LOGQ-1:0] mem0 [N];
  logic [LOGQ-1:0] mem1 [N];

  logic [1:0]      full;
  logic            wbank, rbank;
  logic [LOGN-1:0] wcnt, rcnt;

  logic            wr_fire, rd_fire;
  logic            rd_natural;
  logic [LOGN-1:0] rd_idx;
  logic [LOGQ-1:0] rd_word;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  // Handshakes. A write and a read that fire together always hit different
  // banks: the write bank must be empty and the read bank must be full.
  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

`ifdef REORDER_MODE_EN
  logic [1:0] mode_bank;

  // Capture the block's read order on its first accepted word.
  always_ff @(posedge clk) begin
    if (rst)                        mode_bank <= 2'b00;
    else if (wr_fire && wcnt == '0) mode_bank[wbank] <= mode;
  end

  assign rd_natural = mode_bank[rbank];
`else
  assign rd_natural = 1'b0;
`endif

  // Read side is combinational from registers, so data and last flag stay
  // put while the consumer stalls.
  assign rd_idx   = rd_natural ? rcnt : bitrev(rcnt);
  assign rd_word  = rbank ? mem1[rd_idx] : mem0[rd_idx];
  assign out_data = out_valid ? rd_word : '0;
  assign out_last = out_valid && (rcnt == LAST);

  // Store accepted coefficients into the bank being filled.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wbank) mem1[wcnt] <= in_data;
      else       mem0[wcnt] <= in_data;
    end
  end

  // Counters, bank pointers and full flags. The two full bits are touched
  // at different indices when both block boundaries coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 2'b00;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt  <= '0;
      rcnt  <= '0;
    end else begin
      if (wr_fire) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == LAST) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end
      end
      if (rd_fire) begin
        rcnt <= rcnt + 1'b1;
        if (rcnt == LAST) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
        end
      end
    end
  end

endmodule

// File: tb/tb_ntt_reorder_buf.sv
// Scoreboard bench for ntt_reorder_buf (LOGQ=32, LOGN=4). A negedge monitor
// builds the expected readout of each completed input block and pops it as
// the DUT emits words; scenario tasks add their own directed checks.
module tb_ntt_reorder_buf;
  localparam int LOGQ = 32;
  localparam int LOGN = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [LOGQ-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [LOGQ-1:0] out_data;
  logic            out_last;
`ifdef REORDER_MODE_EN
  logic            mode = 1'b0;
`endif

  ntt_reorder_buf #(.LOGQ(LOGQ), .LOGN(LOGN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
`ifdef REORDER_MODE_EN
    , .mode(mode)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [LOGQ-1:0] d; logic last; } exp_t;
  exp_t            sb[$];
  logic [LOGQ-1:0] obs[$];
  logic [LOGQ-1:0] blk[16];
  int              blk_cnt = 0;
  logic            blk_mode = 1'b0;
  logic [3:0]      idx;
  int              vectors = 0;
  int              miscompares = 0;
  logic            prev_stall = 1'b0;
  logic [LOGQ-1:0] prev_data = '0;
  exp_t            e;

  int br_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  // Monitor and reference model, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      blk_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%0b data=%h, want valid=1 data=%h",
                   out_valid, out_data, prev_data);
        end
      end
      if (!out_valid) begin
        vectors++;
        if (out_data !== '0 || out_last !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_outputs: got data=%h last=%0b, want data=0 last=0",
                   out_data, out_last);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got data=%h, want no output", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_last !== e.last) begin
            miscompares++;
            $display("FAIL out_word: got data=%h last=%0b, want data=%h last=%0b",
                     out_data, out_last, e.d, e.last);
          end
        end
        obs.push_back(out_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) begin
        if (blk_cnt == 0) begin
`ifdef REORDER_MODE_EN
          blk_mode = mode;
`else
          blk_mode = 1'b0;
`endif
        end
        blk[blk_cnt] = in_data;
        blk_cnt++;
        if (blk_cnt == 16) begin
          for (int k = 0; k < 16; k++) begin
            idx = blk_mode ? 4'(k) : 4'(br_tab[k]);
            sb.push_back('{d: blk[idx], last: (k == 15)});
          end
          blk_cnt = 0;
        end
      end
    end
  end

  // Global runaway guard.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  // Present one word and hold it until accepted (bounded).
  task automatic write_word(input logic [LOGQ-1:0] d, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 300) begin
        vectors++;
        miscompares++;
        $display("FAIL write_timeout: got in_ready=0 for %0d cycles, want acceptance", waited);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty (bounded).
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d words pending, want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b last=%0b data=%h, want 1 0 0 0",
               in_ready, out_valid, out_last, out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bitrev_order();
    int w;
    obs.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) write_word(LOGQ'(i), w);
    in_valid = 1'b1;
    in_data  = 32'd15;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_valid: got out_valid=%0b during last write, want 0", out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL valid_latency: got out_valid=%0b after last write, want 1", out_valid);
    end
    drain();
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (k >= obs.size() || obs[k] !== LOGQ'(br_tab[k])) begin
        miscompares++;
        $display("FAIL bitrev_seq[%0d]: got %h, want %0d", k,
                 (k < obs.size()) ? obs[k] : 32'hx, br_tab[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    obs.delete();
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) write_word(32'h100 * (b + 1) + LOGQ'(i), w);
    in_valid = 1'b1;
    in_data  = 32'h300;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h100) begin
        miscompares++;
        $display("FAIL both_full: got rdy=%0b vld=%0b data=%h, want 0 1 00000100",
                 in_ready, out_valid, out_data);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) write_word(32'h300 + LOGQ'(i), w);
    drain();
    vectors++;
    if (obs.size() != 48) begin
      miscompares++;
      $display("FAIL bp_count: got %0d words, want 48", obs.size());
    end else begin
      for (int k = 0; k < 48; k++) begin
        vectors++;
        if (obs[k] !== 32'h100 * (k / 16 + 1) + LOGQ'(br_tab[k % 16])) begin
          miscompares++;
          $display("FAIL bp_word[%0d]: got %h, want %h", k, obs[k],
                   32'h100 * (k / 16 + 1) + LOGQ'(br_tab[k % 16]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int stalls, bubbles, w;
    stalls = 0;
    bubbles = 0;
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 128; i++) write_word(32'h1000 + LOGQ'(i), w);
      for (int c = 1; c <= 144; c++) begin
        @(negedge clk);
        if (c <= 128 && !in_ready) stalls++;
        if (c == 16) begin
          vectors++;
          if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first_valid: got out_valid=1 in cycle 16, want 0");
          end
        end
        if (c >= 17 && !out_valid) bubbles++;
      end
    join
    vectors++;
    if (stalls != 0 || bubbles != 0) begin
      miscompares++;
      $display("FAIL b2b_throughput: got %0d stalls %0d bubbles, want 0 0", stalls, bubbles);
    end
    drain();
  endtask

  task automatic test_random_stall();
    int w;
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) write_word(32'hA000 + LOGQ'($urandom), w);
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid_block();
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) write_word(32'hDEAD00 + LOGQ'(i), w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    obs.delete();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_state: got vld=%0b rdy=%0b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) write_word(LOGQ'(i), w);
    drain();
    vectors++;
    if (obs.size() != 16) begin
      miscompares++;
      $display("FAIL mid_reset_count: got %0d words, want 16", obs.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        vectors++;
        if (obs[k] !== LOGQ'(br_tab[k])) begin
          miscompares++;
          $display("FAIL mid_reset_word[%0d]: got %h, want %0d", k, obs[k], br_tab[k]);
        end
      end
    end
  endtask

`ifdef REORDER_MODE_EN
  task automatic test_mode();
    int w;
    obs.delete();
    out_ready = 1'b1;
    mode = 1'b1;
    for (int i = 0; i < 16; i++) write_word(LOGQ'(i), w);
    mode = 1'b0;
    for (int i = 0; i < 16; i++) write_word(32'h40 + LOGQ'(i), w);
    drain();
    for (int k = 0; k < 32; k++) begin
      vectors++;
      if (k >= obs.size() ||
          obs[k] !== ((k < 16) ? LOGQ'(k) : 32'h40 + LOGQ'(br_tab[k - 16]))) begin
        miscompares++;
        $display("FAIL mode_word[%0d]: got %h, want %h", k,
                 (k < obs.size()) ? obs[k] : 32'hx,
                 (k < 16) ? LOGQ'(k) : 32'h40 + LOGQ'(br_tab[k - 16]));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bitrev_order();
    test_backpressure();
    test_back_to_back();
    test_random_stall();
    test_reset_mid_block();
`ifdef REORDER_MODE_EN
    test_mode();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
